pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central hazard/flow controller for the 5-stage pipeline.
- Generates per-stage hold and flush strobes for the PC, IF/ID and ID/EX registers.
- Sequences multi-cycle EX operations and grants an external whole-pipeline hold (debug/DMA) through a req/ack handshake.
- Keeps saturating stall and flush event counters.

Parameters:
- CNT_W, 32, width of the stall/flush event counters.

Ports:
- clk_100MHz  in  1  system clock.
- arst_n  in  1  synchronous active-low reset.
- jump_ena_i  in  1  EX resolved taken branch/jump.
- jump_addr_i  in  32  jump target from EX.
- ex_mem_r_ena_i  in  1  ID/EX holds a load.
- ex_reg_w_addr_i  in  5  ID/EX destination register.
- id_reg1_r_ena_i  in  1  ID uses rs1.
- id_reg2_r_ena_i  in  1  ID uses rs2.
- id_reg1_r_addr_i  in  5  ID rs1.
- id_reg2_r_addr_i  in  5  ID rs2.
- mc_start_i  in  1  one-cycle pulse, multi-cycle op issued in EX.
- mc_done_i  in  1  multi-cycle op result valid.
- bus_hold_req_i  in  1  external pipeline hold request (level).
- bus_hold_ack_o  out  1  pipeline frozen, external owner may proceed.
- hold_pc_o  out  1  PC keeps its value.
- hold_if_id_o  out  1  IF/ID hold.
- hold_id_ex_o  out  1  ID/EX hold.
- flush_if_id_o  out  1  IF/ID loads bubble.
- flush_id_ex_o  out  1  ID/EX loads bubble.
- jump_ena_o  out  1  PC load strobe.
- jump_addr_o  out  32  PC load target.
- state_o  out  2  current FSM state.
- stall_cnt_o  out  CNT_W  cycles with hold_pc_o=1.
- flush_cnt_o  out  CNT_W  cycles with flush_id_ex_o=1.

Behaviour:
- Reset: all registers update only on the rising edge with arst_n=0.
  - state=RUN(0), counters=0.
  - All strobe outputs are 0 while arst_n=0 (gated combinationally).
  - jump_addr_o=0.
- Reset mid-MC_WAIT or mid-BUS_HOLD returns to RUN; ack drops after that edge.
- FSM states:
  - RUN = 0: normal issue.
  - MC_WAIT = 1: multi-cycle op in EX.
  - BUS_HOLD = 2: pipeline frozen for external owner.
  - Encoding 3 is illegal and goes to RUN.
- Strobe outputs are combinational from state and inputs, same cycle. The state register is sequential.
- Per-register invariant: hold and flush are never 1 together for the same register; this is a bench assertion.
- RUN priority, highest first:
  - Jump (jump_ena_i=1):
    - jump_ena_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1, all holds 0.
    - Next state RUN; mc_start_i is ignored that cycle.
  - Multi-cycle start (mc_start_i=1):
    - hold_pc/if_id/id_ex all 1.
    - Next state MC_WAIT, unless mc_done_i=1 in the same cycle, which gives a zero-wait op: no hold, stay in RUN.
  - External hold (bus_hold_req_i=1):
    - All three holds 1. Next state BUS_HOLD.
    - ack stays 0 this cycle.
  - Load-use hazard:
    - Condition: ex_mem_r_ena_i=1, ex_reg_w_addr_i≠0, and (rs1 used and matches, or rs2 used and matches).
    - Response: hold_pc=1, hold_if_id=1, flush_id_ex=1, hold_id_ex=0. Exactly one bubble; the next cycle re-evaluates. Stay in RUN.
  - Otherwise all strobes 0.
- MC_WAIT:
  - Holds 1 every cycle until mc_done_i=1.
  - In the mc_done_i=1 cycle: holds 0, next state RUN.
  - jump_ena_i, bus_hold_req_i and load-use are ignored. A pending bus request is served after return to RUN.
- BUS_HOLD:
  - bus_hold_ack_o=1 and all holds 1 every cycle in this state.
  - bus_hold_req_i=0: next state RUN. Holds stay 1 in that cycle and ack falls with the state.
  - jump and hazard inputs are ignored.
- jump_addr_o = jump_addr_i when jump_ena_o=1, otherwise 0.
- Counters:
  - stall_cnt +1 each cycle with hold_pc_o=1.
  - flush_cnt +1 each cycle with flush_id_ex_o=1.
  - Both saturate at all-ones, never wrap, and hold on reset until released.

Test Plan:
- Reset, then release with idle inputs → state_o=0, all strobes 0, counters 0; assert arst_n=0 during BUS_HOLD → next cycle state_o=0, ack=0.
- Load-use: ex_mem_r_ena=1, ex_rd=5, id_rs2=5 used → same cycle hold_pc=1, hold_if_id=1, flush_id_ex=1; with ex_rd=0 → no stall; flush_cnt=1 after the event.
- Jump jump_ena_i=1, addr=0x0000_0100, with load-use also true → jump_ena_o=1, jump_addr_o=0x100, both flushes 1, no holds.
- mc_start pulse, mc_done 4 cycles later → holds 1 for 4 cycles, 0 on the done cycle, state 1 then 0, stall_cnt=4; jump_ena_i during the wait is ignored.
- bus_hold_req raised for 6 cycles in RUN → holds from the first cycle, ack 1 from cycle 2 until the cycle after req drops, state returns to 0; req raised during MC_WAIT is granted only after done.
- Preload counters near saturation (CNT_W=4 build), 20 stall cycles → stall_cnt_o stays at 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Hazard and flow controller for the 5-stage pipeline. It drives the per-stage hold/flush strobes,
// sequences multi-cycle EX operations, grants the external bus hold and keeps saturating event counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_100MHz,
  input  logic             arst_n,
  input  logic             jump_ena_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             ex_mem_r_ena_i,
  input  logic [4:0]       ex_reg_w_addr_i,
  input  logic             id_reg1_r_ena_i,
  input  logic             id_reg2_r_ena_i,
  input  logic [4:0]       id_reg1_r_addr_i,
  input  logic [4:0]       id_reg2_r_addr_i,
  input  logic             mc_start_i,
  input  logic             mc_done_i,
  input  logic             bus_hold_req_i,
  output logic             bus_hold_ack_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_ena_o,
  output logic [31:0]      jump_addr_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    BUS_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic hold_all_r, ld_bubble_r, jump_r, ack_r;

  assign load_use = ex_mem_r_ena_i && (ex_reg_w_addr_i != 5'd0) &&
                    ((id_reg1_r_ena_i && (id_reg1_r_addr_i == ex_reg_w_addr_i)) ||
                     (id_reg2_r_ena_i && (id_reg2_r_addr_i == ex_reg_w_addr_i)));

  // RUN arbitrates jump > multi-cycle start > bus hold > load-use; other states freeze everything.
  always_comb begin
    state_d     = state_q;
    hold_all_r  = 1'b0;
    ld_bubble_r = 1'b0;
    jump_r      = 1'b0;
    ack_r       = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_ena_i) begin
          jump_r = 1'b1;
        end else if (mc_start_i) begin
          if (!mc_done_i) begin
            hold_all_r = 1'b1;
            state_d    = MC_WAIT;
          end
        end else if (bus_hold_req_i) begin
          hold_all_r = 1'b1;
          state_d    = BUS_HOLD;
        end else if (load_use) begin
          ld_bubble_r = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_done_i) state_d = RUN;
        else           hold_all_r = 1'b1;
      end
      BUS_HOLD: begin
        ack_r      = 1'b1;
        hold_all_r = 1'b1;
        if (!bus_hold_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Strobes are forced low while reset is asserted; ack follows the registered state.
  assign hold_pc_o      = arst_n && (hold_all_r || ld_bubble_r);
  assign hold_if_id_o   = arst_n && (hold_all_r || ld_bubble_r);
  assign hold_id_ex_o   = arst_n && hold_all_r;
  assign flush_if_id_o  = arst_n && jump_r;
  assign flush_id_ex_o  = arst_n && (jump_r || ld_bubble_r);
  assign jump_ena_o     = arst_n && jump_r;
  assign jump_addr_o    = jump_ena_o ? jump_addr_i : 32'd0;
  assign bus_hold_ack_o = ack_r;
  assign state_o        = state_q;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_pc_o && (stall_cnt_q != '1))     stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_id_ex_o && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: scripted cycles push expected strobe vectors into a queue
// that is popped and compared on the falling edge; counters are checked after the edges.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk_100MHz;
  logic             arst_n;
  logic             jump_ena_i;
  logic [31:0]      jump_addr_i;
  logic             ex_mem_r_ena_i;
  logic [4:0]       ex_reg_w_addr_i;
  logic             id_reg1_r_ena_i, id_reg2_r_ena_i;
  logic [4:0]       id_reg1_r_addr_i, id_reg2_r_addr_i;
  logic             mc_start_i, mc_done_i, bus_hold_req_i;
  logic             bus_hold_ack_o;
  logic             hold_pc_o, hold_if_id_o, hold_id_ex_o;
  logic             flush_if_id_o, flush_id_ex_o;
  logic             jump_ena_o;
  logic [31:0]      jump_addr_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [40:0] exp_q[$];

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_100MHz      (clk_100MHz),
    .arst_n          (arst_n),
    .jump_ena_i      (jump_ena_i),
    .jump_addr_i     (jump_addr_i),
    .ex_mem_r_ena_i  (ex_mem_r_ena_i),
    .ex_reg_w_addr_i (ex_reg_w_addr_i),
    .id_reg1_r_ena_i (id_reg1_r_ena_i),
    .id_reg2_r_ena_i (id_reg2_r_ena_i),
    .id_reg1_r_addr_i(id_reg1_r_addr_i),
    .id_reg2_r_addr_i(id_reg2_r_addr_i),
    .mc_start_i      (mc_start_i),
    .mc_done_i       (mc_done_i),
    .bus_hold_req_i  (bus_hold_req_i),
    .bus_hold_ack_o  (bus_hold_ack_o),
    .hold_pc_o       (hold_pc_o),
    .hold_if_id_o    (hold_if_id_o),
    .hold_id_ex_o    (hold_id_ex_o),
    .flush_if_id_o   (flush_if_id_o),
    .flush_id_ex_o   (flush_id_ex_o),
    .jump_ena_o      (jump_ena_o),
    .jump_addr_o     (jump_addr_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  // clock / reset
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A register must never be told to hold and flush in the same cycle.
  always @(negedge clk_100MHz) begin
    check("inv_if_id", {63'd0, hold_if_id_o & flush_if_id_o}, 64'd0);
    check("inv_id_ex", {63'd0, hold_id_ex_o & flush_id_ex_o}, 64'd0);
  end

  // vector order: {ack, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_ena, state[1:0]}
  function automatic logic [8:0] mk(input logic ack, input logic hp, input logic hif, input logic hex,
                                    input logic fif, input logic fex, input logic je, input logic [1:0] st);
    return {ack, hp, hif, hex, fif, fex, je, st};
  endfunction

  function automatic logic [8:0] v_idle(input logic [1:0] st);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st);
  endfunction

  function automatic logic [8:0] v_hold(input logic ack, input logic [1:0] st);
    return mk(ack, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, st);
  endfunction

  // driver tasks
  task automatic idle_inputs();
    jump_ena_i       = 1'b0;
    jump_addr_i      = $urandom_range(32'hFFFF, 0);
    ex_mem_r_ena_i   = 1'b0;
    ex_reg_w_addr_i  = 5'd0;
    id_reg1_r_ena_i  = 1'b0;
    id_reg2_r_ena_i  = 1'b0;
    id_reg1_r_addr_i = 5'd0;
    id_reg2_r_addr_i = 5'd0;
    mc_start_i       = 1'b0;
    mc_done_i        = 1'b0;
    bus_hold_req_i   = 1'b0;
  endtask

  // Inputs are already driven; push the expectation, compare at negedge, advance past the next posedge.
  task automatic step(input logic [8:0] ev, input logic [31:0] ea, input logic [8:0] mask = 9'h1FF);
    logic [40:0] e;
    logic [8:0]  obs;
    exp_q.push_back({ea, ev});
    @(negedge clk_100MHz);
    e   = exp_q.pop_front();
    obs = {bus_hold_ack_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
           flush_if_id_o, flush_id_ex_o, jump_ena_o, state_o};
    check("strobes", {55'd0, obs & mask}, {55'd0, e[8:0] & mask});
    check("jump_addr", {32'd0, jump_addr_o}, {32'd0, e[40:9]});
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    idle_inputs();
    arst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(v_idle(2'd0), 32'd0);
    arst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    @(posedge clk_100MHz);
    #1;

    // reset gating: a jump request during reset produces no strobe
    jump_ena_i  = 1'b1;
    jump_addr_i = 32'h55;
    step(v_idle(2'd0), 32'd0);
    step(v_idle(2'd0), 32'd0);
    idle_inputs();
    arst_n = 1'b1;
    step(v_idle(2'd0), 32'd0);
    check("rst_stall_cnt", {60'd0, stall_cnt_o}, 64'd0);
    check("rst_flush_cnt", {60'd0, flush_cnt_o}, 64'd0);

    // load-use on rs2
    ex_mem_r_ena_i   = 1'b1;
    ex_reg_w_addr_i  = 5'd5;
    id_reg1_r_ena_i  = 1'b1;
    id_reg1_r_addr_i = 5'd3;
    id_reg2_r_ena_i  = 1'b1;
    id_reg2_r_addr_i = 5'd5;
    step(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0), 32'd0);
    check("lu_flush_cnt", {60'd0, flush_cnt_o}, 64'd1);
    check("lu_stall_cnt", {60'd0, stall_cnt_o}, 64'd1);
    ex_reg_w_addr_i = 5'd0;
    id_reg2_r_addr_i = 5'd0;
    step(v_idle(2'd0), 32'd0);
    // rs1 matches but is unused
    ex_reg_w_addr_i  = 5'd3;
    id_reg1_r_ena_i  = 1'b0;
    id_reg2_r_addr_i = 5'd5;
    step(v_idle(2'd0), 32'd0);
    check("lu_flush_cnt2", {60'd0, flush_cnt_o}, 64'd1);

    // jump beats load-use and mc_start
    ex_reg_w_addr_i = 5'd5;
    jump_ena_i      = 1'b1;
    jump_addr_i     = 32'h0000_0100;
    mc_start_i      = 1'b1;
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0), 32'h100);
    idle_inputs();
    step(v_idle(2'd0), 32'd0);
    check("jmp_flush_cnt", {60'd0, flush_cnt_o}, 64'd2);

    // multi-cycle op: done four cycles after start, jump during wait ignored
    do_reset(1);
    mc_start_i = 1'b1;
    step(v_hold(1'b0, 2'd0), 32'd0);
    mc_start_i = 1'b0;
    step(v_hold(1'b0, 2'd1), 32'd0);
    jump_ena_i  = 1'b1;
    jump_addr_i = 32'hABCD;
    step(v_hold(1'b0, 2'd1), 32'd0);
    jump_ena_i = 1'b0;
    step(v_hold(1'b0, 2'd1), 32'd0);
    mc_done_i = 1'b1;
    step(v_idle(2'd1), 32'd0);
    mc_done_i = 1'b0;
    step(v_idle(2'd0), 32'd0);
    check("mc_stall_cnt", {60'd0, stall_cnt_o}, 64'd4);

    // zero-wait op
    mc_start_i = 1'b1;
    mc_done_i  = 1'b1;
    step(v_idle(2'd0), 32'd0);
    idle_inputs();
    step(v_idle(2'd0), 32'd0);
    check("zw_stall_cnt", {60'd0, stall_cnt_o}, 64'd4);

    // bus hold for six cycles; jump inside the hold ignored
    bus_hold_req_i = 1'b1;
    step(v_hold(1'b0, 2'd0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      jump_ena_i = (i == 2);
      step(v_hold(1'b1, 2'd2), 32'd0);
    end
    jump_ena_i     = 1'b0;
    bus_hold_req_i = 1'b0;
    step(v_hold(1'b1, 2'd2), 32'd0);
    step(v_idle(2'd0), 32'd0);

    // bus request raised during MC_WAIT is served after done
    mc_start_i = 1'b1;
    step(v_hold(1'b0, 2'd0), 32'd0);
    mc_start_i     = 1'b0;
    bus_hold_req_i = 1'b1;
    step(v_hold(1'b0, 2'd1), 32'd0);
    mc_done_i = 1'b1;
    step(v_idle(2'd1), 32'd0);
    mc_done_i = 1'b0;
    step(v_hold(1'b0, 2'd0), 32'd0);
    step(v_hold(1'b1, 2'd2), 32'd0);
    bus_hold_req_i = 1'b0;
    step(v_hold(1'b1, 2'd2), 32'd0);
    step(v_idle(2'd0), 32'd0);

    // reset while in BUS_HOLD: strobes gated in the reset cycle, state/ack clear afterwards
    bus_hold_req_i = 1'b1;
    step(v_hold(1'b0, 2'd0), 32'd0);
    step(v_hold(1'b1, 2'd2), 32'd0);
    arst_n = 1'b0;
    step(v_idle(2'd2), 32'd0, 9'h0FF);
    arst_n = 1'b1;
    bus_hold_req_i = 1'b0;
    step(v_idle(2'd0), 32'd0);
    check("bh_rst_stall_cnt", {60'd0, stall_cnt_o}, 64'd0);

    // stall counter saturation: 20 stall cycles on a 4-bit counter
    mc_start_i = 1'b1;
    step(v_hold(1'b0, 2'd0), 32'd0);
    mc_start_i = 1'b0;
    for (int i = 0; i < 19; i++) step(v_hold(1'b0, 2'd1), 32'd0);
    mc_done_i = 1'b1;
    step(v_idle(2'd1), 32'd0);
    mc_done_i = 1'b0;
    check("sat_stall_cnt", {60'd0, stall_cnt_o}, 64'd15);
    step(v_idle(2'd0), 32'd0);
    check("sat_stall_hold", {60'd0, stall_cnt_o}, 64'd15);

    check("queue_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
